// File: rtl/sim_frame_scheduler.sv
// Frame-loop sequencer for the fluid simulation: debounces the run/step keys, issues ordered
// update/draw start pulses per frame tick, counts finished frames and flags timeouts/overruns.
module sim_frame_scheduler #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int STEP_TIMEOUT    = 1000000,
    parameter int FRAME_CNTW      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_run_n,
    input  logic                  key_step_n,
    input  logic                  frame_tick,
    output logic                  update_start,
    input  logic                  update_done,
    output logic                  draw_start,
    input  logic                  draw_done,
    output logic                  running,
    output logic                  busy,
    output logic [FRAME_CNTW-1:0] frame_count,
    output logic                  timeout_err,
    output logic                  overrun,
    output logic [1:0]            state_dbg
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW  = $clog2(STEP_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_UPDATE = 2'd2,
        S_DRAW   = 2'd3
    } state_t;

    // Key path: index 0 is the run key, index 1 is the step key.
    logic [1:0]     key_raw;
    logic [1:0]     sync1_q, sync2_q;
    logic [1:0]     deb_q, deb_d;
    logic [DBW-1:0] cnt_q [2];
    logic [DBW-1:0] cnt_d [2];
    logic           run_press, step_press;

    state_t                state_q, state_d;
    logic                  running_q, running_d;
    logic                  step_pend_q, step_pend_d;
    logic                  pause_req_q, pause_req_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [FRAME_CNTW-1:0] frame_count_q, frame_count_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  overrun_q, overrun_d;
    logic                  update_start_q, update_start_d;
    logic                  draw_start_q, draw_start_d;
    logic                  timer_expired;

    assign key_raw = {key_step_n, key_run_n};

    // The counter only runs while the synchronized level disagrees with the accepted level,
    // so any sample that agrees again restarts the stability window.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign run_press  = deb_q[0] & ~deb_d[0];
    assign step_press = deb_q[1] & ~deb_d[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            sync1_q  <= key_raw;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end

    assign timer_expired = (timer_q == TW'(STEP_TIMEOUT - 1));

    always_comb begin
        state_d        = state_q;
        running_d      = running_q;
        step_pend_d    = step_pend_q;
        pause_req_d    = pause_req_q;
        timer_d        = timer_q;
        frame_count_d  = frame_count_q;
        timeout_err_d  = timeout_err_q;
        overrun_d      = overrun_q;
        update_start_d = 1'b0;
        draw_start_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (run_press) begin
                    running_d = 1'b1;
                    state_d   = S_WAIT;
                end else if (step_press) begin
                    step_pend_d = 1'b1;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (run_press && running_q) begin
                    running_d = 1'b0;
                    state_d   = S_IDLE;
                end else if (frame_tick) begin
                    update_start_d = 1'b1;
                    timer_d        = '0;
                    state_d        = S_UPDATE;
                end
            end
            S_UPDATE, S_DRAW: begin
                timer_d = timer_q + 1'b1;
                if (run_press) begin
                    pause_req_d = 1'b1;
                end
                if (frame_tick) begin
                    overrun_d = 1'b1;
                end
                // A done coinciding with our own start pulse belongs to an earlier request.
                if (state_q == S_UPDATE && update_done && !update_start_q) begin
                    draw_start_d = 1'b1;
                    timer_d      = '0;
                    state_d      = S_DRAW;
                end else if (state_q == S_DRAW && draw_done && !draw_start_q) begin
                    frame_count_d = frame_count_q + 1'b1;
                    timer_d       = '0;
                    if (step_pend_q || pause_req_d) begin
                        step_pend_d = 1'b0;
                        pause_req_d = 1'b0;
                        running_d   = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (timer_expired) begin
                    timeout_err_d = 1'b1;
                    running_d     = 1'b0;
                    step_pend_d   = 1'b0;
                    pause_req_d   = 1'b0;
                    timer_d       = '0;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            running_q      <= 1'b0;
            step_pend_q    <= 1'b0;
            pause_req_q    <= 1'b0;
            timer_q        <= '0;
            frame_count_q  <= '0;
            timeout_err_q  <= 1'b0;
            overrun_q      <= 1'b0;
            update_start_q <= 1'b0;
            draw_start_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            running_q      <= running_d;
            step_pend_q    <= step_pend_d;
            pause_req_q    <= pause_req_d;
            timer_q        <= timer_d;
            frame_count_q  <= frame_count_d;
            timeout_err_q  <= timeout_err_d;
            overrun_q      <= overrun_d;
            update_start_q <= update_start_d;
            draw_start_q   <= draw_start_d;
        end
    end

    assign update_start = update_start_q;
    assign draw_start   = draw_start_q;
    assign running      = running_q;
    assign busy         = (state_q == S_UPDATE) || (state_q == S_DRAW);
    assign frame_count  = frame_count_q;
    assign timeout_err  = timeout_err_q;
    assign overrun      = overrun_q;
    assign state_dbg    = state_q;

endmodule
